// File: rtl/mips_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// mips_muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - op codes carried on the 3-bit op bus (MD_MULT .. MD_MADDU)
//   - FSM state encoding (ST_IDLE, ST_CALC, ST_FIX, ST_DONE)
//   - helpers for op classification and the CALC iteration count
// -----------------------------------------------------------------------------
package mips_muldiv_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;
  localparam logic [OP_W-1:0] MD_MADD  = 3'd6;
  localparam logic [OP_W-1:0] MD_MADDU = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Number of CALC iterations: one quotient bit per cycle for divides,
  // mbpc multiplier bits per cycle for multiplies.
  function automatic int unsigned md_iter_count(input logic        is_div,
                                                input int unsigned xlen,
                                                input int unsigned mbpc);
    return is_div ? xlen : (xlen / mbpc);
  endfunction

  function automatic logic md_is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// -----------------------------------------------------------------------------
// mips_muldiv_if
// Handshake/data bundle between the EX stage (master) and the multiply/divide
// unit (slave).
//   start   master->slave  launch request, honoured only while the unit is idle
//   op      master->slave  MD_* op code
//   Rdata1  master->slave  rs operand (multiplicand / dividend / MTHI-MTLO data)
//   Rdata2  master->slave  rt operand (multiplier / divisor)
//   busy    slave->master  operation in progress (CALC or FIX)
//   done    slave->master  one-cycle completion pulse
//   div0    slave->master  sticky divide-by-zero flag
//   hi, lo  slave->master  architectural HI/LO registers
// -----------------------------------------------------------------------------
interface mips_muldiv_if
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            start;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] Rdata1;
  logic [XLEN-1:0] Rdata2;
  logic            busy;
  logic            done;
  logic            div0;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, Rdata1, Rdata2,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, Rdata1, Rdata2,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mips_div_step.sv
// -----------------------------------------------------------------------------
// mips_div_step
// One combinational restoring-division step on magnitudes.
//   rem_in        partial remainder (always < divisor in normal operation)
//   divisor       divisor magnitude
//   dividend_bit  next dividend bit shifted into the remainder
//   rem_out       new partial remainder
//   q_bit         quotient bit produced by this step
// -----------------------------------------------------------------------------
module mips_div_step
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  assign shifted = {rem_in, dividend_bit};
  assign trial   = shifted - {1'b0, divisor};

  // The borrow out of the trial subtraction decides the quotient bit. With a
  // zero divisor the trial never borrows, so the quotient fills with ones and
  // the dividend ends up in the remainder.
  assign q_bit   = ~trial[XLEN];
  assign rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_muldiv_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//   CLK   rising-edge clock
//   RST   asynchronous, active-high reset; aborts any operation in flight
//   bus   mips_muldiv_if.slave: start/op/Rdata1/Rdata2 in,
//         busy/done/div0/hi/lo out
// Parameters:
//   XLEN                operand width (even, >= 8)
//   MUL_BITS_PER_CYCLE  multiplier bits retired per CALC cycle (1, 2 or 4)
// Build option:
//   MULDIV_MADD_EN      when defined, MADD/MADDU accumulate the product into
//                       {hi,lo}; otherwise they behave as MULT/MULTU.
// Flow: IDLE -> CALC (N iterations) -> FIX (sign fix-up, HI/LO write)
//       -> DONE (done pulse) -> IDLE. MTHI/MTLO complete directly from IDLE.
// -----------------------------------------------------------------------------
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  mips_muldiv_if.slave bus
);

  localparam int MBPC  = MUL_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [CNT_W-1:0] MUL_ITERS =
    CNT_W'(md_iter_count(1'b0, XLEN, MBPC));
  localparam logic [CNT_W-1:0] DIV_ITERS =
    CNT_W'(md_iter_count(1'b1, XLEN, MBPC));

  // ---------------------------------------------------------------------------
  // State and shadow registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod;     // mul: {partial sum, multiplier}; div: {rem, dividend/quotient}
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic              is_div;
  logic              neg_lo;   // negate product / quotient in FIX
  logic              neg_hi;   // negate remainder in FIX
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              div0_q;
`ifdef MULDIV_MADD_EN
  logic              is_acc;
`endif

  // ---------------------------------------------------------------------------
  // Launch-time operand conditioning
  // ---------------------------------------------------------------------------
  logic            l_is_div;
  logic            b_zero;
  logic            l_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign l_is_div = md_is_div(bus.op);
  assign b_zero   = (bus.Rdata2 == '0);
  // A divide by zero runs unsigned so the result is the raw restoring outcome
  // (quotient all ones, remainder = Rdata1) for DIV and DIVU alike.
  assign l_signed = md_is_signed(bus.op) && !(l_is_div && b_zero);
  assign a_neg    = l_signed && bus.Rdata1[XLEN-1];
  assign b_neg    = l_signed && bus.Rdata2[XLEN-1];
  assign a_mag    = a_neg ? -bus.Rdata1 : bus.Rdata1;
  assign b_mag    = b_neg ? -bus.Rdata2 : bus.Rdata2;

  // ---------------------------------------------------------------------------
  // Shift-add multiply step: retire MBPC multiplier bits from the bottom of
  // prod, add the scaled multiplicand to the upper half, shift right by MBPC.
  // ---------------------------------------------------------------------------
  logic [XLEN+MBPC-1:0] mul_addend;
  logic [XLEN+MBPC-1:0] mul_sum;
  logic [2*XLEN-1:0]    mul_next;

  // NOTE: every signal driven in always_comb gets a default on entry so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mul_addend = '0;
    for (int b = 0; b < MBPC; b++) begin
      if (prod[b]) begin
        mul_addend = mul_addend + ({{MBPC{1'b0}}, opnd} << b);
      end
    end
    mul_sum = {{MBPC{1'b0}}, prod[2*XLEN-1:XLEN]} + mul_addend;
  end

  assign mul_next = {mul_sum, prod[XLEN-1:MBPC]};

  // ---------------------------------------------------------------------------
  // Restoring divide step: dividend MSB shifts into the remainder, quotient
  // bit shifts into the vacated LSB.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] div_next;

  mips_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in       (prod[2*XLEN-1:XLEN]),
    .divisor      (opnd),
    .dividend_bit (prod[XLEN-1]),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );

  assign div_next = {div_rem, prod[XLEN-2:0], div_q};

  // ---------------------------------------------------------------------------
  // FIX-stage result: sign correction and optional accumulation
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [2*XLEN-1:0] fix_result;

  assign quo_fix = neg_lo ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign rem_fix = neg_hi ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = is_div ? {rem_fix, quo_fix} : (neg_lo ? -prod : prod);
`ifdef MULDIV_MADD_EN
    if (is_acc) begin
      fix_result = fix_result + {hi_q, lo_q};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM and register updates
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the shadow registers are reset along with the architectural
      // ones so an aborted operation leaves nothing behind.
      state  <= ST_IDLE;
      cnt    <= '0;
      prod   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      div0_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      is_acc <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            div0_q <= l_is_div && b_zero;
            case (bus.op)
              MD_MTHI: hi_q <= bus.Rdata1;
              MD_MTLO: lo_q <= bus.Rdata1;
              default: begin
                state  <= ST_CALC;
                cnt    <= '0;
                is_div <= l_is_div;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= l_is_div && a_neg;
                if (l_is_div) begin
                  opnd <= b_mag;
                  prod <= {{XLEN{1'b0}}, a_mag};
                end else begin
                  opnd <= a_mag;
                  prod <= {{XLEN{1'b0}}, b_mag};
                end
`ifdef MULDIV_MADD_EN
                is_acc <= (bus.op == MD_MADD) || (bus.op == MD_MADDU);
`endif
              end
            endcase
          end
        end

        ST_CALC: begin
          if (cnt == (is_div ? DIV_ITERS : MUL_ITERS)) begin
            state <= ST_FIX;
          end else begin
            prod <= is_div ? div_next : mul_next;
            cnt  <= cnt + 1'b1;
          end
        end

        ST_FIX: begin
          hi_q  <= fix_result[2*XLEN-1:XLEN];
          lo_q  <= fix_result[XLEN-1:0];
          state <= ST_DONE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done = (state == ST_DONE);
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational HI/LO handling in the execute stage. The EX stage launches MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake. EX reads `hi`/`lo` for MFHI/MFLO and stalls on `busy`.

Parameters:
- XLEN, 32: operand width; HI and LO are each XLEN bits; XLEN even, ≥8.
- MUL_BITS_PER_CYCLE, 1: multiplier bits retired per cycle; 1, 2 or 4; must divide XLEN.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  launch request, sampled only in IDLE.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=MADDU.
- Rdata1  in  XLEN  rs operand (multiplicand/dividend; MTHI/MTLO source).
- Rdata2  in  XLEN  rt operand (multiplier/divisor).
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; HI/LO hold final values.
- div0  out  1  sticky until next accepted start; set on DIV/DIVU with Rdata2==0.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset: CLK and RST as listed; RST is asynchronous and active-high.
  - Outputs reset to state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0.
  - RST mid-operation aborts the operation and discards all partial results.
- States: IDLE, CALC, FIX, DONE.
  - IDLE→CALC on start with op∈{0,1,2,3,6,7}. Operands are latched at this edge.
  - CALC→FIX after N iterations. N = XLEN/MUL_BITS_PER_CYCLE for multiply ops; N = XLEN for divide ops.
  - FIX→DONE after one cycle. HI/LO are written on this edge.
  - DONE→IDLE unconditionally after one cycle.
- Timing: with start sampled at edge 0, done is high during the cycle after edge N+2.
  - XLEN=32, MBPC=1: done follows edge 34 for both multiply and divide.
  - XLEN=32, MBPC=4: multiply done follows edge 10.
- MTHI/MTLO (op 4/5) with start in IDLE:
  - hi (or lo) ← Rdata1 at the next edge.
  - No busy, no done. State stays IDLE.
- Ignored starts:
  - Starts in CALC, FIX or DONE are ignored entirely. The EX stage must stall on busy||done.
  - A start while RST is high is ignored.
- hi/lo during an operation: they hold their old values through CALC/FIX. Intermediates live in internal shadow registers.
- Signed ops (MULT/DIV/MADD):
  - Operands are converted to magnitudes at launch.
  - FIX negates the product if the operand signs differ.
  - FIX negates the quotient if the signs differ; the remainder takes the dividend's sign.
- Multiply: shift-add, producing a 2·XLEN product. {hi,lo} ← product[2XLEN-1:0].
- Divide: restoring, one quotient bit per cycle. lo ← quotient, hi ← remainder.
- Divide by zero:
  - Computation completes with normal latency.
  - Result is lo = all ones and hi = Rdata1 (the unsigned restoring result), for DIVU and DIV alike.
  - div0 = 1.
- Signed overflow (DIV of −2^(XLEN−1) by −1): lo = 0x80000000 (for XLEN=32), hi = 0. No flag.
- MADD/MADDU without MULDIV_MADD_EN: executed exactly as MULT/MULTU.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 6/7 add the signed/unsigned 2·XLEN product to {hi,lo} in FIX, with modulo 2^(2·XLEN) wrap. Latency is unchanged.
- Undefined: ops 6/7 alias MULT/MULTU and no accumulator adder is built.

Decomposition:
- Package mips_muldiv_pkg holds:
  - the op code localparams (MD_MULT … MD_MADDU);
  - the state encoding (ST_IDLE, ST_CALC, ST_FIX, ST_DONE);
  - the helper function for the iteration count.
- One sub-module: mips_div_step. It is a combinational restoring-divide step taking a partial remainder, divisor and next dividend bit, and returning the new remainder and quotient bit. It is instantiated once inside mips_muldiv_unit.

Test Plan:
- MULT, Rdata1=0xFFFFFFFD (−3), Rdata2=5 → after edge 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high edges 1–33.
- DIVU 100/7 → lo=0x0000000E, hi=0x00000002. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → div0=1, lo=0xFFFFFFFF, hi=0x00001234. Next MULTU 2×3 → div0 cleared at launch; hi=0, lo=6.
- Second start at edge 5 during MULT → ignored, original result intact. MTHI 0xABCD in IDLE → hi=0xABCD one edge later, done stays 0.
- RST asserted mid-CALC (edge 10) → busy/done/hi/lo=0 immediately, without waiting for a clock edge. New MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- MULDIV_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Macro undefined: same stimulus → hi=0, lo=1.
